btree_mux_pipe: RTL and testbench
=================================

Name: btree_mux_pipe

Overview:
- Parametrised, pipelined successor to the GPU's combinational rectangle-select mux tree.
- Takes INPUT_COUNT per-rectangle hit flags plus data words for one pixel. Returns whether any flag is set and the data word of the winning entry.
- Pipeline registers are inserted every REG_EVERY tree layers. A valid/ready handshake with a pass-through sideband tag (pixel coordinate) lets the rasteriser run at full clock rate on wide trees.

Parameters:
- INPUT_COUNT, `RECT_COUNT, number of leaves; power of two, 2..256.
- INPUT_WIDTH, `RECT_COUNT_WIDTH, width of each data word.
- TAG_WIDTH, 20, width of the sideband tag carried alongside each pixel.
- REG_EVERY, 2, tree layers per pipeline stage; 1..LAYERS.
- HIGH_WINS, 1, priority direction: 1 = higher index wins (painter's order, later rectangle on top); 0 = lower index wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept the input this cycle
- flags_in  in  INPUT_COUNT  per-leaf select flags
- data_in  in  INPUT_WIDTH x INPUT_COUNT  per-leaf data (unpacked array)
- tag_in  in  TAG_WIDTH  sideband, e.g. pixel x/y
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- flag_out  out  1  OR of all flags_in for this pixel
- data_out  out  INPUT_WIDTH  data of the winning leaf; 0 if no flag set
- tag_out  out  TAG_WIDTH  tag_in of the same pixel

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Tree structure:
  - LAYERS = log2(INPUT_COUNT); STAGES = ceil(LAYERS / REG_EVERY).
  - Each layer halves the node count. A node's output flag is fA|fB.
  - With HIGH_WINS=1 the node output data is fB ? dB : (fA ? dA : 0), where B is the higher-index child. HIGH_WINS=0 swaps the roles of A and B.
  - Unflagged data is forced to 0, so data_out is 0 whenever flag_out is 0.
- Pipeline registers:
  - A register stage sits after layer k when k mod REG_EVERY == 0 or k == LAYERS.
  - Each stage holds node flags, node data, the tag and a valid bit v[s].
  - The final stage drives the outputs directly, with no combinational path from the input to the outputs.
- Latency: exactly STAGES cycles from an accepted input to out_valid, when out_ready is held high. Throughput is 1 pixel per cycle.
- Handshake and stalling:
  - en[STAGES-1] = !v[STAGES-1] | out_ready.
  - en[s] = !v[s] | en[s+1].
  - in_ready = en[0].
  - A stage loads (payload plus v[s] = valid of the previous stage, or in_valid for stage 0) only when en[s] is high. Otherwise it holds all contents.
  - Bubbles collapse: an empty stage loads even while a later stage is stalled.
- Output stability: while out_valid=1 and out_ready=0, flag_out, data_out and tag_out hold stable.
- Input accepted: in_valid & in_ready. Data on flags_in/data_in/tag_in is ignored when in_valid=0, but v[0] is still updated to 0 when en[0] is high.
- Reset:
  - All v[s] = 0, out_valid = 0, flag_out = 0, data_out = 0, tag_out = 0.
  - Reset asserted mid-stream discards all in-flight pixels. in_ready = 1 on the first cycle after reset deasserts.
- Boundary cases:
  - All flags set: the winner is leaf INPUT_COUNT-1 (HIGH_WINS=1) or leaf 0 (HIGH_WINS=0).
  - Single flag: its data passes regardless of position.
  - REG_EVERY ≥ LAYERS: exactly one output register, latency 1.
- Elaboration checks: compile-time assertions that INPUT_COUNT is a power of two ≥ 2 and 1 ≤ REG_EVERY ≤ LAYERS.

Decomposition:
- Shared package (constants.svh / gpu package):
  - RECT_COUNT and RECT_COUNT_WIDTH.
  - A clog2-based LAYERS helper.
  - A typedef for the pixel tag, 10-bit x plus 10-bit y.
- Sub-module btree_mux_node_layer: one combinational layer, parameters INPUT_COUNT, INPUT_WIDTH and HIGH_WINS.
- Top level: instantiates LAYERS layers via generate, and places the stage registers and enable chain between layers.

Test Plan:
- All tests use INPUT_COUNT=64, INPUT_WIDTH=6, REG_EVERY=2 (STAGES=3) unless noted.
- Single flag: flags_in bit 17 set, data_in[17]=6'h2A, tag 0x00123, out_ready=1 -> exactly 3 cycles later out_valid=1, flag_out=1, data_out=6'h2A, tag_out=0x00123.
- Priority: flags at bits 5, 40 and 63; data_in[i]=i -> data_out=63 with HIGH_WINS=1; a rerun with HIGH_WINS=0 gives data_out=5. No flags -> flag_out=0, data_out=0.
- Streaming: 100 back-to-back pixels with random flags, out_ready=1 -> in_ready stays 1, the output sequence matches a reference model in order, and no gaps appear after the first 3-cycle fill.
- Backpressure: stream continuously, drop out_ready for 5 cycles -> in_ready falls after the pipeline fills (3 held pixels), the outputs hold stable, and on release there is no loss or duplication and order is preserved.
- Bubble collapse: send pixel A, idle 2 cycles, send B while out_ready=0 -> B advances into empty stages, and in_ready drops only when all 3 stages are valid.
- Reset: assert rst_n=0 with 3 pixels in flight -> next cycle out_valid=0 and outputs are 0. After release, a new pixel emerges after exactly 3 cycles. A REG_EVERY=6 build shows latency 1.

Source files
------------

// File: rtl/btree_mux_pipe_pkg.sv
// Shared constants and types for the rectangle-select mux tree.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: RECT_COUNT / RECT_COUNT_WIDTH defaults, pixel tag type, tree depth helper.
package btree_mux_pipe_pkg;

   localparam int RECT_COUNT       = 64;
   localparam int RECT_COUNT_WIDTH = 6;

   // Sideband carried next to each pixel: screen coordinate.
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } pixel_tag_t;

   localparam int PIXEL_TAG_WIDTH = $bits(pixel_tag_t);

   // Number of halving layers needed to reduce 'leaves' entries to one.
   function automatic int layers_of(input int leaves);
      return $clog2(leaves);
   endfunction

endpackage

// File: rtl/btree_mux_pipe_if.sv
// Pixel-in / result-out bundle for the pipelined mux tree.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: slave = block view (consumes pixels, produces results); master = rasteriser/sink view.
interface btree_mux_pipe_if
   import btree_mux_pipe_pkg::*;
#(
   parameter int INPUT_COUNT = RECT_COUNT,
   parameter int INPUT_WIDTH = RECT_COUNT_WIDTH,
   parameter int TAG_WIDTH   = PIXEL_TAG_WIDTH
) ();

   logic                   in_valid;
   logic                   in_ready;
   logic [INPUT_COUNT-1:0] flags_in;
   logic [INPUT_WIDTH-1:0] data_in [INPUT_COUNT];
   logic [TAG_WIDTH-1:0]   tag_in;

   logic                   out_valid;
   logic                   out_ready;
   logic                   flag_out;
   logic [INPUT_WIDTH-1:0] data_out;
   logic [TAG_WIDTH-1:0]   tag_out;

   modport slave (
      input  in_valid, flags_in, data_in, tag_in, out_ready,
      output in_ready, out_valid, flag_out, data_out, tag_out
   );

   modport master (
      output in_valid, flags_in, data_in, tag_in, out_ready,
      input  in_ready, out_valid, flag_out, data_out, tag_out
   );

endinterface

// File: rtl/btree_mux_pipe_node_layer.sv
// One combinational layer of the priority mux tree: pairs of children reduce to one node.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
// Ports: flags_in/data_in = INPUT_COUNT children; flags_out/data_out = INPUT_COUNT/2 nodes.
module btree_mux_node_layer
   import btree_mux_pipe_pkg::*;
#(
   parameter int INPUT_COUNT = RECT_COUNT,
   parameter int INPUT_WIDTH = RECT_COUNT_WIDTH,
   parameter bit HIGH_WINS   = 1'b1
) (
   input  logic [INPUT_COUNT-1:0]   flags_in,
   input  logic [INPUT_WIDTH-1:0]   data_in  [INPUT_COUNT],
   output logic [INPUT_COUNT/2-1:0] flags_out,
   output logic [INPUT_WIDTH-1:0]   data_out [INPUT_COUNT/2]
);

   localparam int N_OUT = INPUT_COUNT / 2;

   // Child 2i+1 is the higher-index child. Data of an unflagged pair is
   // forced to 0 so a node never leaks data from a rectangle that missed.
   always_comb begin
      flags_out = '0;
      for (int i = 0; i < N_OUT; i++) begin
         data_out[i] = '0;
      end
      for (int i = 0; i < N_OUT; i++) begin
         flags_out[i] = flags_in[2*i] | flags_in[2*i+1];
         if (HIGH_WINS) begin
            if (flags_in[2*i+1])
               data_out[i] = data_in[2*i+1];
            else if (flags_in[2*i])
               data_out[i] = data_in[2*i];
         end else begin
            if (flags_in[2*i])
               data_out[i] = data_in[2*i];
            else if (flags_in[2*i+1])
               data_out[i] = data_in[2*i+1];
         end
      end
   end

endmodule

// File: rtl/btree_mux_pipe.sv
// Pipelined priority mux tree: OR of hit flags plus data of the winning rectangle, per pixel.
// Latency: STAGES = ceil(log2(INPUT_COUNT)/REG_EVERY) cycles, one pixel per cycle.
// Backpressure: valid/ready per stage; empty stages keep filling while the output is stalled.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of btree_mux_pipe_if).
module btree_mux_pipe
   import btree_mux_pipe_pkg::*;
#(
   parameter int INPUT_COUNT = RECT_COUNT,
   parameter int INPUT_WIDTH = RECT_COUNT_WIDTH,
   parameter int TAG_WIDTH   = PIXEL_TAG_WIDTH,
   parameter int REG_EVERY   = 2,
   parameter bit HIGH_WINS   = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   btree_mux_pipe_if.slave bus
);

   localparam int LAYERS = layers_of(INPUT_COUNT);
   localparam int STAGES = (LAYERS + REG_EVERY - 1) / REG_EVERY;

   if (INPUT_COUNT < 2 || (INPUT_COUNT & (INPUT_COUNT - 1)) != 0) begin : g_bad_count
      $error("btree_mux_pipe: INPUT_COUNT must be a power of two >= 2");
   end
   if (REG_EVERY < 1 || REG_EVERY > LAYERS) begin : g_bad_reg_every
      $error("btree_mux_pipe: REG_EVERY must lie in 1..LAYERS");
   end

   logic [STAGES-1:0] v;   // stage holds a pixel
   logic [STAGES-1:0] en;  // stage may capture this cycle

   // ---------------- valid bits, tags and the enable chain ----------------
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic                 vld;
      logic [TAG_WIDTH-1:0] tag;
      logic                 prev_vld;
      logic [TAG_WIDTH-1:0] prev_tag;

      if (s == 0) begin : g_first
         assign prev_vld = bus.in_valid;
         assign prev_tag = bus.tag_in;
      end else begin : g_next
         assign prev_vld = g_stage[s-1].vld;
         assign prev_tag = g_stage[s-1].tag;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld <= 1'b0;
            tag <= '0;
         end else if (en[s]) begin
            vld <= prev_vld;
            tag <= prev_tag;
         end
      end

      assign v[s] = vld;
      // Unrolled form of en[s] = !v[s] | en[s+1]: a stage can move unless it
      // and every stage after it are full and the sink is not taking.
      assign en[s] = bus.out_ready | ~(&v[STAGES-1:s]);
   end

   // ---------------- tree layers with optional capture registers ----------------
   for (genvar k = 1; k <= LAYERS; k++) begin : g_lay
      localparam int N_IN  = INPUT_COUNT >> (k - 1);
      localparam int N_OUT = N_IN / 2;

      logic [N_IN-1:0]        in_flag;
      logic [INPUT_WIDTH-1:0] in_dat   [N_IN];
      logic [N_OUT-1:0]       comb_flag;
      logic [INPUT_WIDTH-1:0] comb_dat [N_OUT];
      logic [N_OUT-1:0]       out_flag;
      logic [INPUT_WIDTH-1:0] out_dat  [N_OUT];

      if (k == 1) begin : g_src_in
         assign in_flag = bus.flags_in;
         assign in_dat  = bus.data_in;
      end else begin : g_src_prev
         assign in_flag = g_lay[k-1].out_flag;
         assign in_dat  = g_lay[k-1].out_dat;
      end

      btree_mux_node_layer #(
         .INPUT_COUNT (N_IN),
         .INPUT_WIDTH (INPUT_WIDTH),
         .HIGH_WINS   (HIGH_WINS)
      ) u_layer (
         .flags_in  (in_flag),
         .data_in   (in_dat),
         .flags_out (comb_flag),
         .data_out  (comb_dat)
      );

      // Capture after every REG_EVERY-th layer and always after the root,
      // so the outputs never see a combinational path from the inputs.
      if ((k % REG_EVERY) == 0 || k == LAYERS) begin : g_reg
         localparam int S = (k - 1) / REG_EVERY;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_flag <= '0;
               for (int i = 0; i < N_OUT; i++) begin
                  out_dat[i] <= '0;
               end
            end else if (en[S]) begin
               out_flag <= comb_flag;
               out_dat  <= comb_dat;
            end
         end
      end else begin : g_thru
         assign out_flag = comb_flag;
         assign out_dat  = comb_dat;
      end
   end

   // ---------------- outputs ----------------
   assign bus.in_ready  = en[0];
   assign bus.out_valid = v[STAGES-1];
   assign bus.flag_out  = g_lay[LAYERS].out_flag[0];
   assign bus.data_out  = g_lay[LAYERS].out_dat[0];
   assign bus.tag_out   = g_stage[STAGES-1].tag;

endmodule

// File: tb/tb_btree_mux_pipe.sv
// Self-checking bench for btree_mux_pipe: 64 leaves, 6-bit data, three builds side by side.
// Main build (HIGH_WINS=1, REG_EVERY=2) is scoreboarded every cycle; HIGH_WINS=0 and
// REG_EVERY=6 builds share the stimulus and are checked on directed single-pixel shots.
module tb_btree_mux_pipe;
   import btree_mux_pipe_pkg::*;

   localparam int N = 64;
   localparam int W = 6;
   localparam int T = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   btree_mux_pipe_if #(.INPUT_COUNT(N), .INPUT_WIDTH(W), .TAG_WIDTH(T)) bus_m ();
   btree_mux_pipe_if #(.INPUT_COUNT(N), .INPUT_WIDTH(W), .TAG_WIDTH(T)) bus_lo ();
   btree_mux_pipe_if #(.INPUT_COUNT(N), .INPUT_WIDTH(W), .TAG_WIDTH(T)) bus_r6 ();

   btree_mux_pipe #(.INPUT_COUNT(N), .INPUT_WIDTH(W), .TAG_WIDTH(T),
                    .REG_EVERY(2), .HIGH_WINS(1'b1))
      dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
   btree_mux_pipe #(.INPUT_COUNT(N), .INPUT_WIDTH(W), .TAG_WIDTH(T),
                    .REG_EVERY(2), .HIGH_WINS(1'b0))
      dut_lo (.clk(clk), .rst_n(rst_n), .bus(bus_lo));
   btree_mux_pipe #(.INPUT_COUNT(N), .INPUT_WIDTH(W), .TAG_WIDTH(T),
                    .REG_EVERY(6), .HIGH_WINS(1'b1))
      dut_r6 (.clk(clk), .rst_n(rst_n), .bus(bus_r6));

   typedef struct {
      logic         flag;
      logic [W-1:0] dat;
      logic [T-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [N-1:0] cur_flags;
   logic [W-1:0] cur_data [N];
   logic [T-1:0] cur_tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: scan the leaves in priority order, last hit seen wins.
   function automatic exp_t ref_mux(input logic [N-1:0] f, input logic [W-1:0] d [N],
                                    input logic [T-1:0] t, input bit hw);
      exp_t e;
      e.flag = |f;
      e.dat  = '0;
      e.tag  = t;
      if (hw) begin
         for (int i = 0; i < N; i++) if (f[i]) e.dat = d[i];
      end else begin
         for (int i = N - 1; i >= 0; i--) if (f[i]) e.dat = d[i];
      end
      return e;
   endfunction

   // Scoreboard for the main build: inputs and outputs are stable at negedge,
   // and the handshake decided there is the one taken at the next posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (bus_m.out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_valid with empty model", {31'd0, bus_m.out_valid}, 32'd0);
            end else begin
               check("sb flag_out", {31'd0, bus_m.flag_out}, {31'd0, exp_q[0].flag});
               check("sb data_out", {26'd0, bus_m.data_out}, {26'd0, exp_q[0].dat});
               check("sb tag_out",  {12'd0, bus_m.tag_out},  {12'd0, exp_q[0].tag});
               if (bus_m.out_ready) void'(exp_q.pop_front());
            end
         end
         if (bus_m.in_valid && bus_m.in_ready)
            exp_q.push_back(ref_mux(bus_m.flags_in, bus_m.data_in, bus_m.tag_in, 1'b1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic vld);
      bus_m.in_valid  = vld; bus_m.flags_in  = cur_flags; bus_m.tag_in  = cur_tag; bus_m.data_in  = cur_data;
      bus_lo.in_valid = vld; bus_lo.flags_in = cur_flags; bus_lo.tag_in = cur_tag; bus_lo.data_in = cur_data;
      bus_r6.in_valid = vld; bus_r6.flags_in = cur_flags; bus_r6.tag_in = cur_tag; bus_r6.data_in = cur_data;
   endtask

   task automatic rand_data();
      logic [31:0] r;
      for (int i = 0; i < N; i++) begin
         r = $urandom;
         cur_data[i] = r[W-1:0];
      end
   endtask

   task automatic rand_pixel(input int idx);
      logic [31:0] r1, r2, r3, r4;
      rand_data();
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      cur_flags = {r1, r2} & {r3, r4};
      if (idx % 7 == 0) cur_flags = '0;
      cur_tag = idx[T-1:0];
   endtask

   // One isolated pixel into idle pipelines; checks latency and result of all builds.
   task automatic one_shot(input string nm, input logic [N-1:0] f, input logic [T-1:0] t,
                           input logic ef, input logic [W-1:0] ed_hi, input logic [W-1:0] ed_lo);
      int lat_m, lat_lo, lat_r6;
      lat_m = 0; lat_lo = 0; lat_r6 = 0;
      cur_flags = f;
      cur_tag   = t;
      apply(1'b1);
      tick();
      apply(1'b0);
      for (int c = 1; c <= 6; c++) begin
         if (bus_m.out_valid && lat_m == 0) begin
            lat_m = c;
            check({nm, " flag"}, {31'd0, bus_m.flag_out}, {31'd0, ef});
            check({nm, " data"}, {26'd0, bus_m.data_out}, {26'd0, ed_hi});
            check({nm, " tag"},  {12'd0, bus_m.tag_out},  {12'd0, t});
         end
         if (bus_lo.out_valid && lat_lo == 0) begin
            lat_lo = c;
            check({nm, " lo data"}, {26'd0, bus_lo.data_out}, {26'd0, ed_lo});
         end
         if (bus_r6.out_valid && lat_r6 == 0) begin
            lat_r6 = c;
            check({nm, " r6 data"}, {26'd0, bus_r6.data_out}, {26'd0, ed_hi});
            check({nm, " r6 tag"},  {12'd0, bus_r6.tag_out},  {12'd0, t});
         end
         tick();
      end
      check({nm, " latency"},    lat_m,  3);
      check({nm, " lo latency"}, lat_lo, 3);
      check({nm, " r6 latency"}, lat_r6, 1);
   endtask

   initial begin
      exp_t         e;
      logic [N-1:0] pf;
      int           vcount, early, stalls, low_cnt, hi_cnt, idx;
      logic         ready_now, acc_d;

      bus_m.out_ready = 1'b1; bus_lo.out_ready = 1'b1; bus_r6.out_ready = 1'b1;
      cur_flags = '0; cur_tag = '0;
      for (int i = 0; i < N; i++) cur_data[i] = '0;
      apply(1'b0);

      // ---- reset state ----
      repeat (3) tick();
      check("reset out_valid", {31'd0, bus_m.out_valid}, 32'd0);
      check("reset flag_out",  {31'd0, bus_m.flag_out},  32'd0);
      check("reset data_out",  {26'd0, bus_m.data_out},  32'd0);
      check("reset tag_out",   {12'd0, bus_m.tag_out},   32'd0);
      check("reset r6 out_valid", {31'd0, bus_r6.out_valid}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("in_ready after reset", {31'd0, bus_m.in_ready}, 32'd1);
      tick();

      // ---- pin the reference model against hand-computed values ----
      for (int i = 0; i < N; i++) cur_data[i] = i[W-1:0];
      pf = '0; pf[5] = 1'b1; pf[40] = 1'b1; pf[63] = 1'b1;
      e = ref_mux(pf, cur_data, 20'h0, 1'b1);
      check("model high wins", {26'd0, e.dat}, 32'd63);
      e = ref_mux(pf, cur_data, 20'h0, 1'b0);
      check("model low wins", {26'd0, e.dat}, 32'd5);
      e = ref_mux('0, cur_data, 20'h0, 1'b1);
      check("model no flag", {25'd0, e.flag, e.dat}, 32'd0);

      // ---- single flag at several positions ----
      rand_data(); cur_data[17] = 6'h2A;
      one_shot("single17", 64'd1 << 17, 20'h00123, 1'b1, 6'h2A, 6'h2A);
      rand_data(); cur_data[0] = 6'h15;
      one_shot("single0", 64'd1, 20'h00001, 1'b1, 6'h15, 6'h15);
      rand_data(); cur_data[63] = 6'h3F;
      one_shot("single63", 64'd1 << 63, 20'hFFFFF, 1'b1, 6'h3F, 6'h3F);

      // ---- priority, all flags, no flags ----
      for (int i = 0; i < N; i++) cur_data[i] = i[W-1:0];
      one_shot("prio", pf, 20'h00ABC, 1'b1, 6'd63, 6'd5);
      one_shot("all", '1, 20'h12345, 1'b1, 6'd63, 6'd0);
      rand_data(); cur_data[0] = 6'h3F;
      one_shot("none", '0, 20'h00777, 1'b0, 6'd0, 6'd0);

      // ---- streaming 100 back-to-back pixels ----
      vcount = 0; early = 0; stalls = 0;
      for (int i = 0; i < 100; i++) begin
         rand_pixel(i + 1);
         apply(1'b1);
         if (!bus_m.in_ready) stalls++;
         tick();
         if (bus_m.out_valid) begin
            if (i >= 2) vcount++;
            else early++;
         end
      end
      apply(1'b0);
      for (int k = 101; k <= 105; k++) begin
         tick();
         if (k <= 102 && bus_m.out_valid) vcount++;
      end
      check("stream in_ready stalls", stalls, 0);
      check("stream early outputs", early, 0);
      check("stream gapless outputs", vcount, 100);
      check("stream drained", exp_q.size(), 0);

      // ---- backpressure: out_ready low for 5 cycles mid-stream ----
      low_cnt = 0; hi_cnt = 0; idx = 1000;
      rand_pixel(idx);
      apply(1'b1);
      for (int c = 0; c < 25; c++) begin
         bus_m.out_ready = !(c >= 10 && c < 15);
         #1;
         if (c >= 10 && c < 15) begin
            if (!bus_m.in_ready) low_cnt++;
         end else begin
            if (bus_m.in_ready) hi_cnt++;
         end
         ready_now = bus_m.in_ready;
         tick();
         if (ready_now) begin
            idx++;
            rand_pixel(idx);
            apply(1'b1);
         end
      end
      bus_m.out_ready = 1'b1;
      apply(1'b0);
      repeat (6) tick();
      check("bp in_ready low while stalled", low_cnt, 5);
      check("bp in_ready high while flowing", hi_cnt, 20);
      check("bp drained", exp_q.size(), 0);

      // ---- bubble collapse ----
      bus_m.out_ready = 1'b0;
      rand_pixel(2000); apply(1'b1); tick();
      apply(1'b0); tick(); tick();
      check("bubble A at output", {31'd0, bus_m.out_valid}, 32'd1);
      check("bubble A tag", {12'd0, bus_m.tag_out}, 32'd2000);
      rand_pixel(2001); apply(1'b1);
      #1;
      check("bubble B accepted", {31'd0, bus_m.in_ready}, 32'd1);
      tick();
      apply(1'b0); tick();
      check("bubble B advanced", {31'd0, bus_m.in_ready}, 32'd1);
      rand_pixel(2002); apply(1'b1); tick();
      rand_pixel(2003); apply(1'b1);
      #1;
      check("bubble full in_ready", {31'd0, bus_m.in_ready}, 32'd0);
      tick(); tick();
      check("bubble hold in_ready", {31'd0, bus_m.in_ready}, 32'd0);
      check("bubble hold tag", {12'd0, bus_m.tag_out}, 32'd2000);
      bus_m.out_ready = 1'b1;
      acc_d = 1'b0;
      for (int c = 0; c < 5 && !acc_d; c++) begin
         #1;
         if (bus_m.in_ready) acc_d = 1'b1;
         tick();
      end
      check("bubble D accepted", {31'd0, acc_d}, 32'd1);
      apply(1'b0);
      repeat (6) tick();
      check("bubble drained", exp_q.size(), 0);

      // ---- reset with pixels in flight ----
      for (int i = 0; i < 3; i++) begin
         rand_pixel(3000 + i); cur_flags[i] = 1'b1;
         apply(1'b1); tick();
      end
      apply(1'b0);
      rst_n = 1'b0;
      tick();
      check("mid reset out_valid", {31'd0, bus_m.out_valid}, 32'd0);
      check("mid reset flag_out",  {31'd0, bus_m.flag_out},  32'd0);
      check("mid reset data_out",  {26'd0, bus_m.data_out},  32'd0);
      check("mid reset tag_out",   {12'd0, bus_m.tag_out},   32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("post reset in_ready", {31'd0, bus_m.in_ready}, 32'd1);
      rand_data(); cur_data[9] = 6'h11;
      one_shot("post reset", 64'd1 << 9, 20'h00456, 1'b1, 6'h11, 6'h11);
      check("final drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
